// File: rtl/mode_sequencer_pkg.sv
// Shared constants for the pattern sequencer: index range, FSM encoding, default timing.
// Index wrap helpers live here so the top and any future users agree on 9->0 / 0->9.
package mode_sequencer_pkg;

    localparam int         PATTERN_COUNT = 10;
    localparam logic [3:0] MAX_IDX       = 4'(PATTERN_COUNT - 1);

    localparam logic [0:0] ST_MAN  = 1'b0;
    localparam logic [0:0] ST_AUTO = 1'b1;

    localparam int DWELL_DEFAULT = 1000;
    localparam int DEB_DEFAULT   = 16;
    localparam int DWELL_W       = 24;
    localparam int DEB_W         = 8;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DN   = 2'd2
    } step_e;

    function automatic logic [3:0] idx_inc(input logic [3:0] idx);
        return (idx >= MAX_IDX) ? 4'd0 : idx + 4'd1;
    endfunction

    function automatic logic [3:0] idx_dec(input logic [3:0] idx);
        return (idx == 4'd0) ? MAX_IDX : idx - 4'd1;
    endfunction

endpackage

// File: rtl/mode_sequencer_if.sv
// Button inputs and pattern outputs of the mode sequencer, bundled for port connection.
interface mode_sequencer_if;

    logic       nxt;
    logic       prv;
    logic       aut;
    logic [3:0] q;
    logic       stp;
    logic       amode;

    modport master (output nxt, prv, aut, input q, stp, amode);
    modport slave  (input nxt, prv, aut, output q, stp, amode);

endinterface

// File: rtl/mode_sequencer_btn_cond.sv
// Push-button conditioner: 2-flop synchronizer, DEB-cycle debouncer, rising-edge event.
module btn_cond
    import mode_sequencer_pkg::*;
#(
    parameter int DEB = DEB_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_evt
);

    localparam logic [DEB_W-1:0] CNT_TC = DEB_W'(DEB - 1);

    logic [1:0]       r_sync;
    logic             r_level;
    logic             r_level_d;
    logic [DEB_W-1:0] r_cnt;

    // NOTE: non-blocking assignments so every flop samples pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync    <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync    <= {r_sync[0], i_btn};
            r_level_d <= r_level;
            // Any return to the accepted level restarts the stability window.
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_TC) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_evt = r_level & ~r_level_d;

endmodule

// File: rtl/mode_sequencer.sv
// Pattern index sequencer: manual next/prev stepping plus an auto mode that advances
// the index every DWELL cycles. Buttons are conditioned by three btn_cond instances.
module mode_sequencer
    import mode_sequencer_pkg::*;
#(
    parameter int DWELL = DWELL_DEFAULT,
    parameter int DEB   = DEB_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    mode_sequencer_if.slave  bus
);

    localparam logic [DWELL_W-1:0] DWELL_TC = DWELL_W'(DWELL - 1);

    logic w_nxt_evt;
    logic w_prv_evt;
    logic w_aut_evt;

    btn_cond #(.DEB(DEB)) u_nxt (.clk(clk), .rst(rst), .i_btn(bus.nxt), .o_evt(w_nxt_evt));
    btn_cond #(.DEB(DEB)) u_prv (.clk(clk), .rst(rst), .i_btn(bus.prv), .o_evt(w_prv_evt));
    btn_cond #(.DEB(DEB)) u_aut (.clk(clk), .rst(rst), .i_btn(bus.aut), .o_evt(w_aut_evt));

    logic [0:0]         r_state;
    logic [3:0]         r_q;
    logic               r_stp;
    logic [DWELL_W-1:0] r_dwell;

    step_e w_man_step;
    logic  w_dwell_tc;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_man_step = STEP_NONE;
        if (w_nxt_evt && !w_prv_evt) begin
            w_man_step = STEP_UP;
        end else if (w_prv_evt && !w_nxt_evt) begin
            w_man_step = STEP_DN;
        end
    end

    assign w_dwell_tc = (r_state == ST_AUTO) && (r_dwell == DWELL_TC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_MAN;
            r_q     <= '0;
            r_stp   <= 1'b0;
            r_dwell <= '0;
        end else begin
            if (w_aut_evt) begin
                r_state <= ~r_state;
            end

            // Out-of-range recovery beats manual steps, which beat the dwell step.
            r_stp <= 1'b1;
            if (r_q > MAX_IDX) begin
                r_q <= '0;
            end else if (w_man_step == STEP_UP) begin
                r_q <= idx_inc(r_q);
            end else if (w_man_step == STEP_DN) begin
                r_q <= idx_dec(r_q);
            end else if (w_dwell_tc) begin
                r_q <= idx_inc(r_q);
            end else begin
                r_stp <= 1'b0;
            end

            if (r_state == ST_MAN || w_aut_evt || w_man_step != STEP_NONE || w_dwell_tc) begin
                r_dwell <= '0;
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

    assign bus.q     = r_q;
    assign bus.stp   = r_stp;
    assign bus.amode = (r_state == ST_AUTO);

endmodule

// File: doc/mode_sequencer.md
MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 SHALL have parameter DWELL, default 1000: clock cycles per pattern step in AUTO state (legal range 2..2^24-1).
REQ-002 SHALL have parameter DEB, default 16: cycles a synchronized button must stay stable to be accepted (legal range 2..255).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 nxt  input  1  raw "next pattern" push-button; asynchronous, active-high.
REQ-006 prv  input  1  raw "previous pattern" push-button; asynchronous, active-high.
REQ-007 aut  input  1  raw "auto/manual toggle" push-button; asynchronous, active-high.
REQ-008 q  output  4  current pattern index 0..9, binary; drives the 4-to-10 one-hot pattern decoder.
REQ-009 stp  output  1  one-cycle pulse in the cycle q changes value.
REQ-010 amode  output  1  high while the FSM is in AUTO.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer, then a debounce counter; the debounced level changes only after DEB consecutive cycles of a new synchronized value.
REQ-012 A button event SHALL be a single-cycle rising edge of the debounced level; a held button produces one event only.
REQ-013 FSM SHALL have two states: MAN (reset state) and AUTO; an aut event toggles MAN<->AUTO.
REQ-014 On a nxt event alone, q SHALL become q+1, wrapping 9->0.
REQ-015 On a prv event alone, q SHALL become q-1, wrapping 0->9.
REQ-016 nxt and prv events in the same cycle SHALL cancel: q holds and stp stays low.
REQ-017 In AUTO, a dwell counter SHALL count 0..DWELL-1; at terminal count it wraps to 0 and q advances by +1 with 9->0 wrap.
REQ-018 In AUTO, a manual nxt/prv step SHALL take priority over a same-cycle dwell step (exactly one step, in the manual direction) and SHALL clear the dwell counter to 0.
REQ-019 Entering AUTO SHALL clear the dwell counter; the first auto step occurs DWELL cycles after the entry edge.
REQ-020 In MAN the dwell counter SHALL be held at 0.
REQ-021 An aut event coinciding with nxt/prv SHALL apply both: the step is taken and the state toggles.
REQ-022 q SHALL never hold 10..15; any such value (e.g. from an upset) SHALL be replaced by 0 on the next clock edge, with stp asserted.
REQ-023 Latency: a q update and its stp pulse SHALL occur in the same clock edge as the internal event; button-pin to q latency = 2 sync + DEB + 1 edge-detect cycles, nominally 19 cycles at DEB=16.
REQ-024 q, stp and amode SHALL be registered outputs with no combinational path from the inputs.

Reset
REQ-025 While rst is high: q=0, stp=0, amode=0, FSM=MAN, dwell counter=0, debounce counters=0, synchronizer and debounced levels=0.
REQ-026 Reset asserted mid-operation (including mid-dwell or mid-debounce) SHALL abort immediately with no step pulse; after release, a button already held low-to-high SHALL need a full DEB window before producing an event.
REQ-027 Deassertion SHALL be synchronized to clk externally; the block requires no extra cycles after release.

Structure
REQ-028 A shared package SHALL hold: pattern count (10), max index (9), FSM state encoding (MAN=0, AUTO=1), and default DWELL/DEB values.
REQ-029 One sub-module, btn_cond (synchronizer + debouncer + rising-edge detector, parameter DEB), SHALL be instantiated three times.
REQ-030 mode_sequencer SHALL contain only the FSM, index counter and dwell counter around the btn_cond instances.

Verification (DWELL=8, DEB=4 unless stated)
REQ-031 Reset, then pulse nxt high for 10 cycles, ten times -> q steps 1,2,...,9,0; ten stp pulses; amode=0 throughout.
REQ-032 From q=0, pulse prv once -> q=9; then hold nxt high for 100 cycles -> q=0 and exactly one stp pulse.
REQ-033 Toggle nxt at 1-cycle period for 20 cycles, then release -> no event, q unchanged; also raise nxt and prv on the same cycle and hold both for 10 cycles -> q unchanged, stp=0.
REQ-034 Pulse aut -> amode=1; q advances every 8 cycles and wraps 9->0; a nxt event injected at dwell count 5 -> one step only, and the next auto step occurs 8 cycles after the injection.
REQ-035 In AUTO with q=6 at dwell count 3, assert rst for 1 cycle -> q=0, amode=0, stp=0; with no further input q stays 0 for at least 50 cycles.
REQ-036 Force the internal q register to 12 -> next edge q=0 with stp=1; a sampled assertion confirms q<=9 in every later cycle.
